// File: rtl/uart_pkg.sv
// Types and constants shared by the UART receiver, transmitter and RX buffer.
// Holds the byte type and the level/ack handshake state encoding.
package uart_pkg;

    localparam int unsigned UART_DBITS = 8;

    typedef logic [UART_DBITS-1:0] uart_byte_t;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ACK      = 2'd1,
        WAIT_LOW = 2'd2
    } uart_hs_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO with an explicit fill counter.
// Pushes while full are accepted only when a pop happens in the same cycle.
module sync_fifo #(
    parameter int unsigned DBITS      = 8,
    parameter int unsigned DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic                  pop,
    input  logic [DBITS-1:0]      wdata,
    output logic [DBITS-1:0]      rdata,
    output logic                  full,
    output logic                  empty,
    output logic [DEPTH_LOG2:0]   level
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_LEVEL = (DEPTH_LOG2 + 1)'(DEPTH);

    logic [DBITS-1:0]      mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]   level_q, level_d;
    logic                  push_en, pop_en;

    always_comb begin
        empty   = (level_q == '0);
        full    = (level_q == FULL_LEVEL);
        pop_en  = pop && !empty;
        push_en = push && (!full || pop_en);

        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push_en) wr_ptr_d = wr_ptr_q + DEPTH_LOG2'(1);
        if (pop_en)  rd_ptr_d = rd_ptr_q + DEPTH_LOG2'(1);
        case ({push_en, pop_en})
            2'b10:   level_d = level_q + (DEPTH_LOG2 + 1)'(1);
            2'b01:   level_d = level_q - (DEPTH_LOG2 + 1)'(1);
            default: level_d = level_q;
        endcase

        // Head is forced to zero while empty so the port reads 0 out of reset.
        rdata = empty ? '0 : mem_q[rd_ptr_q];
        level = level_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_en) mem_q[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/uart_rx_fifo.sv
// Receive-side byte buffer: takes bytes from the UART receiver's level/ack
// handshake, queues them, and offers them to the soc with a sticky overflow flag.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int unsigned DBITS      = UART_DBITS,
    parameter int unsigned DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  sync_rstn,
    input  logic [DBITS-1:0]      in_data,
    input  logic                  in_ready,
    output logic                  in_ack,
    output logic [DBITS-1:0]      out_data,
    output logic                  out_ready,
    input  logic                  out_ack,
    output logic [DEPTH_LOG2:0]   level,
    output logic                  overflow,
    input  logic                  clear_ovf
);

    uart_hs_state_e state_q, state_d;
    logic           overflow_q, overflow_d;
    logic           capture, push, drop, pop_fire, push_ok;
    logic           fifo_full, fifo_empty;

    always_comb begin
        state_d = state_q;
        in_ack  = 1'b0;
        capture = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_ready) begin
                    capture = 1'b1;
                    state_d = ACK;
                end
            end
            ACK: begin
                in_ack  = 1'b1;
                state_d = WAIT_LOW;
            end
            WAIT_LOW: begin
                if (!in_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // A capture is always acknowledged; when full with no pop the byte is dropped.
    always_comb begin
        pop_fire   = out_ack && !fifo_empty;
        push_ok    = !fifo_full || pop_fire;
        push       = capture && push_ok;
        drop       = capture && !push_ok;
        overflow_d = overflow_q;
        if (drop)           overflow_d = 1'b1;
        else if (clear_ovf) overflow_d = 1'b0;
        out_ready  = !fifo_empty;
        overflow   = overflow_q;
    end

    always_ff @(posedge clk or negedge sync_rstn) begin
        if (!sync_rstn) begin
            state_q    <= IDLE;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            overflow_q <= overflow_d;
        end
    end

    sync_fifo #(
        .DBITS      (DBITS),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_fifo (
        .clk   (clk),
        .rst_n (sync_rstn),
        .push  (push),
        .pop   (out_ack),
        .wdata (in_data),
        .rdata (out_data),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (level)
    );

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
- Receive-side byte buffer between uart_receiver and the soc serial RX port.
- Consumes the receiver's level/ack handshake (data_ready / data_ack / data_out) and stores bytes in a DEPTH-entry FIFO.
- Presents the same style of handshake to the soc (serial_rx_data / serial_rx_ready / serial_rx_ack), so the CPU can lag several characters without losing data.
- Sticky overflow flag and fill level for software diagnostics.

Parameters:
- DBITS, 8: data bits per word.
- DEPTH_LOG2, 4: log2 of FIFO depth; depth = 16 by default.

Ports:
- clk, input, 1: system clock.
- sync_rstn, input, 1: reset, asynchronous assert, active-low.
- in_data, input, DBITS: byte from uart_receiver data_out.
- in_ready, input, 1: uart_receiver data_ready; level, held until acked.
- in_ack, output, 1: to uart_receiver data_ack; one-cycle pulse.
- out_data, output, DBITS: head-of-FIFO byte to soc.
- out_ready, output, 1: FIFO non-empty.
- out_ack, input, 1: soc pop request.
- level, output, DEPTH_LOG2+1: number of stored bytes, 0..DEPTH.
- overflow, output, 1: sticky; a byte was dropped because the FIFO was full.
- clear_ovf, input, 1: one-cycle pulse clears overflow.

Behaviour:
- Reset (sync_rstn=0, asynchronous): wr_ptr=rd_ptr=0, level=0, in-side FSM=IDLE, in_ack=0, out_ready=0, overflow=0, out_data=0 (the memory itself is not reset).
- Storage: DEPTH x DBITS register array. Pointers are DEPTH_LOG2 bits and wrap naturally from DEPTH-1 to 0. level is kept as a separate counter.
- out_data = mem[rd_ptr], combinational (first-word fall-through). out_ready = (level != 0).
- In-side FSM states:
  - IDLE: if in_ready=1, go to ACK. At this clock edge, the byte is written to mem[wr_ptr] and wr_ptr is incremented if a push is allowed. Otherwise the byte is discarded and overflow is set.
  - ACK: in_ack=1 for exactly this one cycle, then go to WAIT_LOW.
  - WAIT_LOW: in_ack=0; stay until in_ready=0, then go to IDLE. This guarantees exactly one capture per receiver byte, even if the receiver drops data_ready late.
- Push allowed = (level < DEPTH) || pop_this_cycle.
  - Full with a simultaneous pop: both succeed, level stays at DEPTH, no overflow.
- Full with no pop: the byte is still acknowledged, so the receiver never stalls. The byte is dropped and overflow is set to 1 on the next edge.
- Pop: pop_this_cycle = out_ack && (level != 0).
  - rd_ptr increments on the edge.
  - A pop while empty is ignored with no state change.
  - out_ack held high for k cycles pops k bytes, limited by level.
- level update: +1 on push only, -1 on pop only, unchanged on both or neither.
- Latency: in_ready rises in cycle N → byte written at the end of N → out_ready=1 and level updated in cycle N+1 → in_ack=1 in cycle N+1. Minimum spacing between captures is 3 cycles (IDLE → ACK → WAIT_LOW → IDLE).
- overflow/clear_ovf: clear_ovf clears overflow. If clear_ovf coincides with a new drop in the same cycle, the set wins and overflow stays 1.
- Mid-operation reset discards all buffered bytes. If in_ready is still high after reset release, it is captured as a new byte.

Decomposition:
- Shared package uart_pkg holds: UART_DBITS=8; the in-side FSM state enum (IDLE, ACK, WAIT_LOW); and typedef uart_byte_t. These are shared with uart_receiver and uart_transmitter.
- One natural sub-module: sync_fifo (DBITS, DEPTH_LOG2). It contains the memory, pointers and level, with push/pop/full/empty ports.
- uart_rx_fifo wraps sync_fifo with the in-side FSM and the overflow logic.

Test Plan:
- Single byte: hold in_ready=1 with in_data=8'hA5 until in_ack → exactly one in_ack pulse, one cycle after capture. out_ready=1, out_data=8'hA5, level=1. Pulse out_ack → level=0, out_ready=0.
- Ordering and wrap: push 8'h00..8'h13 (20 bytes) while popping after every 2nd push → reads return 8'h00..8'h13 in order across pointer wrap, overflow=0.
- Full and overflow: push 17 bytes 8'h10..8'h20 with no pops → level=16, overflow=1, in_ack pulsed 17 times. Pops return 8'h10..8'h1F; 8'h20 is lost.
- Simultaneous events at full: level=16, out_ack=1 in the same cycle as capture → level stays 16, overflow stays 0, head advances. Then clear_ovf coincident with a new drop → overflow remains 1.
- Slow receiver deassert: in_ready held high 10 cycles after in_ack → only one byte stored, level=1.
- Reset mid-operation: level=5, assert sync_rstn=0 asynchronously, mid-cycle → level=0, out_ready=0, in_ack=0, overflow=0 immediately, without waiting for a clock edge.
- End-to-end: in the soc bench, uart_transmitter sends "Hi" into uart_receiver → uart_rx_fifo → soc reads 8'h48 then 8'h69.
